// File: rtl/splitter_seq.sv
// Byte splitter sequencer: latches a 32-bit word, emits its bytes MSB first over valid/ready.
// Define SPLITTER_SEQ_CHAIN_EN to accept the next word on the last-byte edge (no idle bubble).
module splitter_seq #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [7:0]       out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic [CNT_W-1:0] words_done
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t           state, state_n;
  logic [31:0]      w, w_n;
  logic [1:0]       idx, idx_n;
  logic [CNT_W-1:0] words_done_n;
  logic             in_xfer, out_xfer;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      w          <= '0;
      idx        <= '0;
      words_done <= '0;
    end else begin
      state      <= state_n;
      w          <= w_n;
      idx        <= idx_n;
      words_done <= words_done_n;
    end
  end

  // out_valid is a pure decode of the state register, so it is registered.
  assign out_valid = (state == SEND);
  assign out_last  = (state == SEND) && (idx == 2'd3);

  always_comb begin
    out_data = '0;
    if (state == SEND) begin
      case (idx)
        2'd0:    out_data = w[31:24];
        2'd1:    out_data = w[23:16];
        2'd2:    out_data = w[15:8];
        default: out_data = w[7:0];
      endcase
    end
  end

  always_comb begin
    in_ready = 1'b0;
    if (!reset) begin
      if (state == IDLE) begin
        in_ready = 1'b1;
      end
`ifdef SPLITTER_SEQ_CHAIN_EN
      else if (idx == 2'd3) begin
        in_ready = out_ready;
      end
`endif
    end
  end

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  always_comb begin
    state_n      = state;
    w_n          = w;
    idx_n        = idx;
    words_done_n = words_done;
    case (state)
      IDLE: begin
        if (in_xfer) begin
          state_n = SEND;
          w_n     = in_data;
          idx_n   = '0;
        end
      end
      SEND: begin
        if (out_xfer) begin
          if (idx != 2'd3) begin
            idx_n = idx + 2'd1;
          end else begin
            words_done_n = words_done + CNT_W'(1);
            idx_n        = '0;
            // in_xfer can only be high here when chaining is enabled.
            if (in_xfer) begin
              w_n = in_data;
            end else begin
              state_n = IDLE;
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_splitter_seq.sv
// Directed self-checking bench for splitter_seq; a second CNT_W=2 instance covers counter wrap.
module tb_splitter_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, out_ready;
  logic [31:0] in_data;
  logic        in_ready, out_valid, out_last;
  logic [7:0]  out_data;
  logic [15:0] words_done;

  logic        in_valid2, out_ready2;
  logic [31:0] in_data2;
  logic        in_ready2, out_valid2, out_last2;
  logic [7:0]  out_data2;
  logic [1:0]  words_done2;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  splitter_seq #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .words_done(words_done)
  );

  splitter_seq #(.CNT_W(2)) dut_wrap (
    .clk(clk), .reset(reset),
    .in_valid(in_valid2), .in_data(in_data2), .in_ready(in_ready2),
    .out_valid(out_valid2), .out_data(out_data2), .out_last(out_last2),
    .out_ready(out_ready2), .words_done(words_done2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accepts one word with out_ready high, checks all four bytes, ends just after the last-byte edge.
  task automatic xfer_word(input logic [31:0] d, input logic [15:0] done_before);
    in_valid = 1'b1;
    in_data  = d;
    out_ready = 1'b1;
    #1;
    check("xw_in_ready", {31'b0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      check("xw_valid", {31'b0, out_valid}, 32'd1);
      check("xw_byte", {24'b0, out_data}, {24'b0, 8'(d >> (24 - 8 * i))});
      check("xw_last", {31'b0, out_last}, {31'b0, (i == 3)});
      check("xw_cnt_hold", {16'b0, words_done}, {16'b0, done_before});
      step();
    end
    check("xw_idle", {31'b0, out_valid}, 32'd0);
    check("xw_cnt", {16'b0, words_done}, {16'b0, done_before + 16'd1});
  endtask

  initial begin
    logic [7:0] b2b [8];
    logic [1:0] wrap_exp [5];
    b2b      = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    wrap_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    in_valid2 = 1'b0; in_data2 = '0; out_ready2 = 1'b0;

    // Reset defaults
    step();
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    step();
    check("rst_in_ready2", {31'b0, in_ready}, 32'd0);
    reset = 1'b0;
    #1;
    check("rst_rel_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_data", {24'b0, out_data}, 32'd0);
    check("rst_out_last", {31'b0, out_last}, 32'd0);
    check("rst_words_done", {16'b0, words_done}, 32'd0);

    // Single word
    xfer_word(32'hDCF00731, 16'd0);

    // Backpressure on the second byte
    in_valid = 1'b1; in_data = 32'hDCF00731; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("bp_b0", {24'b0, out_data}, 32'hDC);
    check("bp_in_ready_busy", {31'b0, in_ready}, 32'd0);
    step();
    check("bp_b1", {24'b0, out_data}, 32'hF0);
    out_ready = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      step();
      check("bp_hold_data", {24'b0, out_data}, 32'hF0);
      check("bp_hold_valid", {31'b0, out_valid}, 32'd1);
      check("bp_hold_last", {31'b0, out_last}, 32'd0);
    end
    out_ready = 1'b1;
    step();
    check("bp_b2", {24'b0, out_data}, 32'h07);
    step();
    check("bp_b3", {24'b0, out_data}, 32'h31);
    check("bp_b3_last", {31'b0, out_last}, 32'd1);
    step();
    check("bp_idle", {31'b0, out_valid}, 32'd0);
    check("bp_cnt", {16'b0, words_done}, 32'd2);

    // Back-to-back words with in_valid and out_ready held high
    in_valid = 1'b1; in_data = 32'h11223344; out_ready = 1'b1;
    step();
    in_data = 32'hAABBCCDD;
    for (int unsigned i = 0; i < 4; i++) begin
      check("b2b_valid", {31'b0, out_valid}, 32'd1);
      check("b2b_byte", {24'b0, out_data}, {24'b0, b2b[i]});
      if (i == 3) begin
`ifdef SPLITTER_SEQ_CHAIN_EN
        check("b2b_chain_ready", {31'b0, in_ready}, 32'd1);
`else
        check("b2b_chain_ready", {31'b0, in_ready}, 32'd0);
`endif
      end
      step();
    end
`ifndef SPLITTER_SEQ_CHAIN_EN
    check("b2b_bubble", {31'b0, out_valid}, 32'd0);
    check("b2b_bubble_ready", {31'b0, in_ready}, 32'd1);
    step();
`endif
    in_valid = 1'b0;
    for (int unsigned i = 4; i < 8; i++) begin
      check("b2b_valid", {31'b0, out_valid}, 32'd1);
      check("b2b_byte", {24'b0, out_data}, {24'b0, b2b[i]});
      check("b2b_last", {31'b0, out_last}, {31'b0, (i == 7)});
      step();
    end
    check("b2b_idle", {31'b0, out_valid}, 32'd0);
    check("b2b_cnt", {16'b0, words_done}, 32'd4);

    // Reset mid-word after two bytes
    in_valid = 1'b1; in_data = 32'h55667788; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("mid_b0", {24'b0, out_data}, 32'h55);
    step();
    check("mid_b1", {24'b0, out_data}, 32'h66);
    step();
    reset = 1'b1;
    step();
    check("mid_in_ready", {31'b0, in_ready}, 32'd0);
    reset = 1'b0;
    #1;
    check("mid_valid", {31'b0, out_valid}, 32'd0);
    check("mid_last", {31'b0, out_last}, 32'd0);
    check("mid_cnt", {16'b0, words_done}, 32'd0);
    xfer_word(32'h01020304, 16'd0);

    // Counter wrap on the CNT_W=2 instance
    out_ready2 = 1'b1;
    for (int unsigned k = 0; k < 5; k++) begin
      in_valid2 = 1'b1;
      in_data2  = 32'hA0B0C0D0 + k;
      step();
      in_valid2 = 1'b0;
      for (int unsigned i = 0; i < 4; i++) step();
      check("wrap_cnt", {30'b0, words_done2}, {30'b0, wrap_exp[k]});
      check("wrap_idle", {31'b0, out_valid2}, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
